// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the 8-way round-robin arbiter.
//   N_REQ / IDX_W    : requester count and encoded-index width
//   arb_state_t      : FSM encoding (IDLE=0, GRANT=1)
//   arb_dbg_t        : observable FSM state and priority pointer
//   onehot_to_idx()  : 8-to-3 encoder, also used by the existing encoder logic
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        arb_state_t       state;
        logic [IDX_W-1:0] ptr;
    } arb_dbg_t;

    // OR of the indices of all set bits; exact for a one-hot or zero input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin pick.
//   req     [7:0] in  : request vector
//   ptr     [2:0] in  : index holding highest priority
//   pick    [2:0] out : first set request scanning ptr, ptr+1, ... modulo 8
//   any_req       out : at least one request is set
// Implementation: rotate so ptr sits at bit 0, find lowest set bit,
// then add ptr back (3-bit add wraps modulo 8).
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any_req
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   offset;

    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N_REQ-1:0];
        offset  = '0;
        // Scan downward so the lowest set bit (closest to ptr) wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = IDX_W'(i);
        end
        pick    = ptr + offset;
        any_req = |req;
    end

endmodule

// File: rtl/arb_rr8.sv
// arb_rr8: round-robin arbiter, 8 requesters, one shared resource.
// Grant is held until the owner raises done; on release the pointer moves
// to owner+1 and the next pending request (if any) is granted at the same
// edge. All outputs are registered.
//
// Ports:
//   clk          in       rising-edge clock
//   rst          in       synchronous active-high reset
//   req    [7:0] in       request vector
//   done         in       owner releases (only looked at while granted)
//   grant  [7:0] out      one-hot grant, zero when idle
//   grant_idx[2:0] out    encoded grant index, zero when idle
//   grant_valid  out      a grant is held
//   timeout      out      one-cycle pulse on forced release
//   dbg          out      FSM state and priority pointer
//
// Optional: define ARB_TIMEOUT_EN to enable the hold counter and forced
// release after MAX_HOLD cycles; otherwise timeout is tied 0 and there
// is no MAX_HOLD parameter.
module arb_rr8
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout,
    output arb_dbg_t         dbg
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             timeout_q;

    logic             force_rel;
    logic             release_now;
    logic [IDX_W-1:0] ptr_sel;
    logic [IDX_W-1:0] pick;
    logic             any_req;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;

    assign force_rel = (state_q == GRANT) && !done &&
                       (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
    assign force_rel = 1'b0;
`endif

    assign release_now = (state_q == GRANT) && (done || force_rel);
    // On release the new pointer is used for the same-edge re-arbitration.
    assign ptr_sel     = release_now ? (idx_q + IDX_W'(1)) : ptr_q;

    arb_rr_pick u_pick (
        .req     (req),
        .ptr     (ptr_sel),
        .pick    (pick),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << pick;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    grant_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = ptr_sel;
                    if (any_req) begin
                        grant_d = N_REQ'(1) << pick;
`ifdef ARB_TIMEOUT_EN
                        hold_d  = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            idx_q     <= onehot_to_idx(grant_d);
            valid_q   <= (state_d == GRANT);
            timeout_q <= force_rel;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;
    assign dbg.state   = state_q;
    assign dbg.ptr     = ptr_q;

endmodule

// File: tb/tb_arb_rr8.sv
// tb_arb_rr8: directed scenarios plus random traffic for arb_rr8, checked
// every cycle against a behavioural round-robin model.
module tb_arb_rr8;
    import arb_pkg::*;

    localparam int TB_MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    arb_dbg_t   dbg;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ARB_TIMEOUT_EN
    arb_rr8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
`else
    arb_rr8 dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .dbg         (dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 when idle; ptr is the highest-priority index.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 0;
    bit m_live  = 0;

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit rel;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0; m_live = 1;
        end else if (m_owner < 0) begin
            m_to = 0;
            if (req != 0) begin
                m_owner = rr_pick(req, m_ptr);
                m_hold  = 0;
            end
        end else begin
            rel  = done;
            m_to = 0;
`ifdef ARB_TIMEOUT_EN
            if (!done && m_hold == TB_MAX_HOLD - 1) begin
                rel  = 1;
                m_to = 1;
            end
`endif
            if (rel) begin
                m_ptr = (m_owner + 1) % 8;
                if (req != 0) begin
                    m_owner = rr_pick(req, m_ptr);
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("grant",       32'(grant),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("grant_idx",   32'(grant_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
            check("timeout",     32'(timeout),     32'(m_to));
            check("state",       32'(dbg.state),   32'(m_owner >= 0));
            check("ptr",         32'(dbg.ptr),     32'(m_ptr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic [7:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
    endtask

    task automatic do_reset();
        drive(1, 8'h00, 0);
        step();
        step();
        drive(0, 8'h00, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(1, 8'h00, 0);
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(grant_valid), 32'd0);

        // Single requester, hold then release.
        drive(0, 8'b0000_1000, 0);
        step();
        check("t1_grant", 32'(grant), 32'h08);
        check("t1_idx", 32'(grant_idx), 32'd3);
        for (int i = 0; i < 5; i++) step();
        check("t1_hold", 32'(grant), 32'h08);
        drive(0, 8'h00, 1);
        step();
        check("t1_rel_valid", 32'(grant_valid), 32'd0);
        check("t1_rel_ptr", 32'(dbg.ptr), 32'd4);
        drive(0, 8'h00, 0);

        // Back-to-back handoff 0,7,0,7.
        do_reset();
        drive(0, 8'b1000_0001, 1);
        step(); check("t2_a", 32'(grant_idx), 32'd0);
        step(); check("t2_b", 32'(grant_idx), 32'd7);
        step(); check("t2_c", 32'(grant_idx), 32'd0);
        step(); check("t2_d", 32'(grant_idx), 32'd7);
        check("t2_valid", 32'(grant_valid), 32'd1);
        drive(0, 8'h00, 1);
        step();
        drive(0, 8'h00, 0);

        // Wrap-around order from ptr=6.
        do_reset();
        drive(0, 8'b0010_0000, 0);
        step();
        drive(0, 8'h00, 1);
        step();
        check("t3_ptr", 32'(dbg.ptr), 32'd6);
        drive(0, 8'b0100_0011, 0);
        step(); check("t3_a", 32'(grant_idx), 32'd6);
        drive(0, 8'b0100_0011, 1);
        step(); check("t3_b", 32'(grant_idx), 32'd0);
        step(); check("t3_c", 32'(grant_idx), 32'd1);
        drive(0, 8'h00, 1);
        step();
        drive(0, 8'h00, 0);

        // Owner drops req, grant held until done.
        drive(0, 8'b0000_0100, 0);
        step();
        drive(0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step();
        check("t4_hold", 32'(grant), 32'h04);
        drive(0, 8'h00, 1);
        step();
        check("t4_idle", 32'(grant), 32'd0);
        check("t4_idx", 32'(grant_idx), 32'd0);
        drive(0, 8'h00, 0);

        // Reset together with done mid-grant.
        do_reset();
        drive(0, 8'b0010_0000, 0);
        step();
        check("t5_idx", 32'(grant_idx), 32'd5);
        drive(1, 8'b0010_0000, 1);
        step();
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_ptr", 32'(dbg.ptr), 32'd0);
        drive(0, 8'b0010_0001, 0);
        step();
        check("t5_regrant", 32'(grant_idx), 32'd0);
        drive(0, 8'h00, 1);
        step();

        // Hold without done: forced release or indefinite hold.
        drive(0, 8'b0001_0010, 0);
        step();
        check("t6_first", 32'(grant_idx), 32'd1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < TB_MAX_HOLD - 1; i++) step();
        check("t6_held", 32'(grant_idx), 32'd1);
        step();
        check("t6_moved", 32'(grant_idx), 32'd4);
        check("t6_pulse", 32'(timeout), 32'd1);
        step();
        check("t6_pulse_end", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 20; i++) step();
        check("t6_held", 32'(grant_idx), 32'd1);
        check("t6_no_to", 32'(timeout), 32'd0);
`endif
        drive(0, 8'h00, 1);
        step();
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) r = r & 8'($urandom_range(0, 255));
            drive(($urandom_range(0, 149) == 0), r, ($urandom_range(0, 2) == 0));
            step();
        end
        drive(0, 8'h00, 0);
        step();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
